// File: rtl/ql_pkg.sv
// ---------------------------------------------------------------------------
// ql_pkg
// Shared definitions for the Q-learning maze agent: the action index enum,
// the selector FSM states, the agent-wide Q-value width, the LFSR feedback
// mask and a helper that turns an action index into its one-hot form.
// No ports (package).
// ---------------------------------------------------------------------------
package ql_pkg;

    // Q-value width shared by the agent, the reward generator and the selector
    localparam int Q_W = 16;

    // Galois feedback mask for the 16-bit LFSR (taps 16,14,13,11)
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } action_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sel_state_t;

    // bit0=up, bit1=down, bit2=left, bit3=right
    function automatic logic [3:0] action_onehot(input action_t act);
        return 4'b0001 << act;
    endfunction

endpackage

// File: rtl/action_selector_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR that advances only when asked to, so its sequence is a
// pure function of how many steps have been taken since reset.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset, loads SEED
//   step   in   advance the register by one position this cycle
//   value  out  current LFSR contents
// ---------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] value
);
    import ql_pkg::*;

    // Right-shifting Galois form: when the bit falling out of the bottom is 1
    // the mask is folded back in. SEED must be nonzero or the register would
    // lock up at all-zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (step) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/action_selector.sv
// ---------------------------------------------------------------------------
// action_selector
// Epsilon-greedy action chooser. Each accepted request scans the four
// Q-values of the current state, keeps the signed argmax (lowest index wins
// ties), then uses a latched LFSR draw to either explore (random action) or
// exploit (argmax). The result is presented one-hot on next_action.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   en            in   global enable; everything holds while low
//   start         in   decision request, honoured only when idle
//   epsilon       in   exploration threshold, latched on accept
//   q_rd          out  Q-table read strobe
//   q_act         out  action index being read
//   q_value       in   signed Q-table data, one enabled cycle after q_rd
//   next_action   out  one-hot chosen action, held until the next decision
//   action_valid  out  pulses when next_action updates
//   explore       out  last decision was a random one
//   busy          out  decision in progress
// ---------------------------------------------------------------------------
module action_selector #(
    parameter int          Q_W       = ql_pkg::Q_W,
    parameter int          EPS_W     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [EPS_W-1:0]      epsilon,
    output logic                  q_rd,
    output logic [1:0]            q_act,
    input  logic signed [Q_W-1:0] q_value,
    output logic [3:0]            next_action,
    output logic                  action_valid,
    output logic                  explore,
    output logic                  busy
);
    import ql_pkg::*;

    sel_state_t            state;
    sel_state_t            state_nxt;
    logic                  accept;

    logic [1:0]            rd_cnt;
    logic [EPS_W-1:0]      eps_lat;
    logic [9:0]            rnd;
    logic [15:0]           lfsr_value;
    logic                  unused_lfsr_hi;

    logic signed [Q_W-1:0] best_val;
    action_t               best_idx;

    logic                  cmp_en;
    logic [1:0]            cmp_idx;
    logic                  cmp_take;
    action_t               final_idx;
    logic [EPS_W-1:0]      rnd_cmp;
    logic                  go_explore;
    action_t               chosen_idx;

    // Only the low ten bits of each draw matter: [7:0] against epsilon and
    // [9:8] as the random action.
    assign unused_lfsr_hi = ^lfsr_value[15:10];
    assign rnd_cmp        = EPS_W'(rnd[7:0]);
    assign q_act          = rd_cnt;

    // The random source advances exactly once per accepted request, so the
    // draw used by decision N is always the Nth LFSR state after reset.
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (accept),
        .value (lfsr_value)
    );

    // State register. Holding on en=0 is handled in the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode. READ walks the four actions, DRAIN
    // catches the data for the last read, DONE is the cycle in which the
    // freshly registered decision is visible. Nothing advances without en.
    always_comb begin
        state_nxt = state;
        q_rd      = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && en) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                q_rd = 1'b1;
                if (en && rd_cnt == 2'd3) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Compare and decide. Data arriving in READ belongs to the previous
    // read index; data in DRAIN is always action 3. Action 0 loads the
    // running best unconditionally, later ones need a strictly greater
    // signed value so ties stay on the lower index. final_idx folds in the
    // last comparison so the decision can be registered on the DRAIN edge.
    always_comb begin
        cmp_en     = en && ((state == READ && rd_cnt != 2'd0) || state == DRAIN);
        cmp_idx    = (state == DRAIN) ? 2'd3 : rd_cnt - 2'd1;
        cmp_take   = (cmp_idx == 2'd0) || (q_value > best_val);
        final_idx  = cmp_take ? action_t'(cmp_idx) : best_idx;
        go_explore = rnd_cmp < eps_lat;
        chosen_idx = go_explore ? action_t'(rnd[9:8]) : final_idx;
    end

    // Datapath registers. On accept the threshold and draw are captured and
    // the running best is cleared. The read index advances through READ and
    // wraps back to zero on entering DRAIN. The decision and its valid pulse
    // are registered on the DRAIN edge so they are seen during DONE; the
    // full scan always runs, so latency does not depend on exploring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt       <= 2'd0;
            eps_lat      <= '0;
            rnd          <= '0;
            best_val     <= '0;
            best_idx     <= UP;
            next_action  <= 4'b0001;
            action_valid <= 1'b0;
            explore      <= 1'b0;
        end else if (en) begin
            action_valid <= (state == DRAIN);
            if (accept) begin
                eps_lat  <= epsilon;
                rnd      <= lfsr_value[9:0];
                best_val <= '0;
                best_idx <= UP;
                rd_cnt   <= 2'd0;
            end
            if (state == READ) begin
                rd_cnt <= rd_cnt + 2'd1;
            end
            if (cmp_en && cmp_take) begin
                best_val <= q_value;
                best_idx <= action_t'(cmp_idx);
            end
            if (state == DRAIN) begin
                next_action <= action_onehot(chosen_idx);
                explore     <= go_explore;
            end
        end
    end

endmodule

// File: tb/tb_action_selector.sv
// ---------------------------------------------------------------------------
// tb_action_selector
// Directed bench for action_selector. Stimulus tasks push the expected
// decision into a scoreboard queue; an independent monitor pops and checks
// every action_valid pulse (action, explore flag, latency in cycles).
// ---------------------------------------------------------------------------
module tb_action_selector;

    logic               clk;
    logic               rst;
    logic               en;
    logic               start;
    logic [7:0]         epsilon;
    logic               q_rd;
    logic [1:0]         q_act;
    logic signed [15:0] q_value;
    logic [3:0]         next_action;
    logic               action_valid;
    logic               explore;
    logic               busy;

    typedef struct {
        logic [3:0] act;
        logic       expl;
        int         acc_cyc;
        int         lat;
    } exp_t;

    exp_t               sb[$];
    exp_t               item;
    logic signed [15:0] q_table [4];
    int                 cyc;
    int                 n_checks;
    int                 n_pass;
    int                 obs_explores;
    logic               prev_valid;

    action_selector #(
        .Q_W       (16),
        .EPS_W     (8),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .epsilon      (epsilon),
        .q_rd         (q_rd),
        .q_act        (q_act),
        .q_value      (q_value),
        .next_action  (next_action),
        .action_valid (action_valid),
        .explore      (explore),
        .busy         (busy)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure decision latency
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Q-table model: returns the requested entry one enabled cycle after the
    // strobe and holds it while en is low
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_value <= '0;
        end else if (en && q_rd) begin
            q_value <= q_table[q_act];
        end
    end

    // Watchdog so the bench always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks = n_checks + 1;
        if (got === want) begin
            n_pass = n_pass + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard monitor: one pop per rising edge of action_valid
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (action_valid && !prev_valid) begin
                checkOutput("pending_expect", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    item = sb.pop_front();
                    checkOutput("next_action", 32'(next_action), 32'(item.act));
                    checkOutput("explore", 32'(explore), 32'(item.expl));
                    checkOutput("latency", 32'(cyc - item.acc_cyc + 1), 32'(item.lat));
                    if (explore) obs_explores = obs_explores + 1;
                end
            end
            prev_valid = action_valid;
        end
    end

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_wait", 32'(busy), 32'd0);
    endtask

    // Issue one decision; stall>0 drops en for that many cycles from cycle 2
    task automatic applyStimulus(input logic [7:0] eps,
                                 input logic signed [15:0] qa, input logic signed [15:0] qb,
                                 input logic signed [15:0] qc, input logic signed [15:0] qd,
                                 input logic [3:0] exp_act, input logic exp_expl,
                                 input int stall);
        logic busy_ok;
        logic qseq_ok;
        int   nreads;
        waitIdle();
        q_table[0] = qa;
        q_table[1] = qb;
        q_table[2] = qc;
        q_table[3] = qd;
        epsilon    = eps;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        sb.push_back('{exp_act, exp_expl, cyc, 6 + stall});
        busy_ok = 1'b1;
        qseq_ok = 1'b1;
        nreads  = 0;
        for (int p = 1; p <= 6 + stall; p++) begin
            en = !(stall > 0 && p >= 2 && p < 2 + stall);
            if (!busy) busy_ok = 1'b0;
            if (q_rd && en) begin
                if (nreads >= 4 || q_act != 2'(nreads)) qseq_ok = 1'b0;
                nreads++;
            end
            @(negedge clk);
        end
        en = 1'b1;
        checkOutput("busy_during", 32'(busy_ok), 32'd1);
        checkOutput("q_act_seq", 32'(qseq_ok), 32'd1);
        checkOutput("read_count", 32'(nreads), 32'd4);
        checkOutput("busy_after", 32'(busy), 32'd0);
    endtask

    // Keep start high across n decisions; expect one accept per 7 cycles
    task automatic applyHeld(input int n);
        logic busy_ok;
        waitIdle();
        q_table[0] = 16'sd0;
        q_table[1] = 16'sd0;
        q_table[2] = 16'sd0;
        q_table[3] = 16'sd1;
        epsilon    = 8'h00;
        start      = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            sb.push_back('{4'b1000, 1'b0, cyc, 6});
            busy_ok = 1'b1;
            for (int p = 1; p <= 6; p++) begin
                if (!busy) busy_ok = 1'b0;
                @(negedge clk);
            end
            checkOutput("held_busy", 32'(busy_ok), 32'd1);
            checkOutput("held_idle_c7", 32'(busy), 32'd0);
            if (k == n - 1) start = 1'b0;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_next_action"}, 32'(next_action), 32'h1);
        checkOutput({tag, "_explore"}, 32'(explore), 32'd0);
        checkOutput({tag, "_action_valid"}, 32'(action_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_q_rd"}, 32'(q_rd), 32'd0);
        checkOutput({tag, "_q_act"}, 32'(q_act), 32'd0);
    endtask

    // Main sequence
    initial begin
        logic [15:0] m;
        logic [15:0] r;
        logic        ex;
        logic [3:0]  act;
        int          model_explores;

        n_checks     = 0;
        n_pass       = 0;
        obs_explores = 0;
        rst          = 1'b1;
        en           = 1'b1;
        start        = 1'b0;
        epsilon      = 8'h00;
        for (int i = 0; i < 4; i++) q_table[i] = '0;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        // First draw after reset is 0xACE1: 0xE1 < 0xFF, random index 0
        applyStimulus(8'hFF, 16'sd5, -16'sd3, 16'sd12, 16'sd7, 4'b0001, 1'b1, 0);
        // Greedy pick: 12 at index 2
        applyStimulus(8'h00, 16'sd5, -16'sd3, 16'sd12, 16'sd7, 4'b0100, 1'b0, 0);
        // Tie on negatives: -2 at index 1 beats the later -2
        applyStimulus(8'h00, -16'sd8, -16'sd2, -16'sd2, -16'sd9, 4'b0010, 1'b0, 0);
        // Signed extremes: 32767 at index 2 beats 0x8000/0x8001
        applyStimulus(8'h00, -16'sd32768, -16'sd32767, 16'sd32767, 16'sd32767, 4'b0100, 1'b0, 0);
        // All equal resolves to index 0
        applyStimulus(8'h00, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 4'b0001, 1'b0, 0);
        // Enable dropped for 3 cycles during READ: valid in cycle 9
        applyStimulus(8'h00, 16'sd1, 16'sd2, 16'sd3, 16'sd40, 4'b1000, 1'b0, 3);

        // start held high: three decisions, one per 7 cycles
        applyHeld(3);

        // Abort a decision with reset in cycle 3
        waitIdle();
        q_table[0] = 16'sd9;
        q_table[1] = 16'sd1;
        q_table[2] = 16'sd1;
        q_table[3] = 16'sd1;
        epsilon    = 8'h00;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetValues("abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 256 decisions at epsilon 0x80 against a reference LFSR
        m              = 16'hACE1;
        model_explores = 0;
        obs_explores   = 0;
        for (int i = 0; i < 256; i++) begin
            r   = m;
            m   = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
            ex  = (r[7:0] < 8'h80);
            act = ex ? (4'b0001 << r[9:8]) : 4'b1000;
            if (ex) model_explores++;
            applyStimulus(8'h80, 16'sd1, 16'sd2, 16'sd3, 16'sd4, act, ex, 0);
        end
        repeat (3) @(negedge clk);
        checkOutput("explore_count", 32'(obs_explores), 32'(model_explores));
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/action_selector.md
# action_selector

Epsilon-greedy action chooser for the Q-learning maze agent. On each decision request it reads the four Q-values of the current state serially and tracks the greedy argmax. A 16-bit LFSR draw then decides between exploring (random action) and exploiting (argmax). The one-hot result drives `next_action` into the state selector.

## Interface
Parameters:
- `Q_W`, 16: signed Q-value width; matches the agent's reward/Q width.
- `EPS_W`, 8: epsilon threshold width.
- `LFSR_SEED`, 16'hACE1: LFSR value on reset; must be nonzero.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable; when low, the FSM, LFSR and all registers hold.
- `start`  in  1  decision request; accepted only in IDLE with `en`=1.
- `epsilon`  in  EPS_W  exploration threshold, sampled at accept.
- `q_rd`  out  1  Q-table read strobe.
- `q_act`  out  2  action index being read.
- `q_value`  in  Q_W  signed Q-table read data; valid exactly one enabled cycle after the `q_rd` cycle.
- `next_action`  out  4  one-hot action: bit0=up, bit1=down, bit2=left, bit3=right; held until the next accept.
- `action_valid`  out  1  one-cycle pulse when `next_action` updates.
- `explore`  out  1  1 if the last decision was random; updates with `action_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- **IDLE**
  - On `start`&`en`: latch `epsilon`; latch `rnd` = current LFSR value.
  - Step the LFSR once, using Galois feedback with mask 16'hB400.
  - Clear `best_val` and `best_idx`; go to READ.
- **READ** (4 cycles)
  - `q_rd`=1 with `q_act` = 0, 1, 2, 3 in successive cycles; go to DRAIN after `q_act`=3.
- **Compare rule**
  - The first returned value (action 0) loads `best_val`/`best_idx` unconditionally.
  - Each later value replaces them only if it is strictly greater (signed compare).
  - Ties resolve to the lowest index.
- **DRAIN** (1 cycle)
  - Capture and compare the last value (action 3); go to DONE.
- **DONE** (1 cycle)
  - Explore if `rnd[7:0]` < latched `epsilon`, compared unsigned on EPS_W bits.
  - Explore: action index = `rnd[9:8]`, `explore`=1.
  - Exploit: action index = `best_idx`, `explore`=0.
  - Register the one-hot encoding to `next_action`, pulse `action_valid`, return to IDLE.
- The full Q scan runs even when exploring, so latency is constant.
- `start` outside IDLE is ignored; no queueing.
- Boundary values of `epsilon`:
  - `epsilon`=0: never explores.
  - `epsilon`=all-ones: explores unless `rnd[7:0]`=255.
- The LFSR steps only on accepted starts, so its sequence is deterministic per decision count.

## Timing
- Reset values:
  - FSM = IDLE; LFSR = `LFSR_SEED`.
  - `next_action` = 4'b0001; `action_valid`=0, `explore`=0, `busy`=0, `q_rd`=0, `q_act`=0.
- Cycle numbering: accept edge = cycle 0.
  - `q_rd` high in cycles 1–4.
  - Data is compared in cycles 2–5.
  - `action_valid` is high in cycle 6.
- A new `start` can be accepted in cycle 7, giving a throughput of 1 decision per 7 enabled cycles.
- `en` low stretches every phase by the number of disabled cycles.
  - The read pipeline stalls with it: the Q-table must hold `q_value` while `en`=0.
- `rst` mid-operation immediately returns to IDLE with all reset values; no `action_valid` is produced for the aborted decision.
- No combinational path from inputs to outputs.

## Structure
- Shared package `ql_pkg`:
  - `action_t` index enum (UP=0, DOWN=1, LEFT=2, RIGHT=3).
  - One-hot encode function.
  - `Q_W` constant shared with the agent and reward generator.
  - LFSR mask constant 16'hB400.
- Sub-module `lfsr16`:
  - Ports: `clk`, `rst`, `step`, `seed` parameter, `value` output.
  - Instantiated once; reusable by the agent for tie-breaking later.

## Test plan
- Greedy pick: after reset, Q = {5, −3, 12, 7}, `epsilon`=0 → `action_valid` in cycle 6, `next_action`=4'b0100, `explore`=0, `busy` high in cycles 1–6.
- Exploration draw: first decision after reset, `epsilon`=8'hFF.
  - `rnd`=0xACE1, so 0xE1 < 0xFF → explore, index `rnd[9:8]`=0.
  - Required: `next_action`=4'b0001, `explore`=1.
- Tie and negatives: Q = {−8, −2, −2, −9}, `epsilon`=0 → `next_action`=4'b0010, confirming lowest index on tie and signed compare.
- Enable stall: drop `en` for 3 cycles during READ → `action_valid` in cycle 9; the `q_act` sequence 0..3 has no skips or repeats.
- Protocol abuse:
  - `start` held high continuously → one decision per 7 cycles and no accepts while `busy`.
  - `rst` asserted in cycle 3 → outputs return to reset values the same cycle, with no `action_valid` pulse.
- LFSR determinism: 256 decisions with `epsilon`=8'h80 → the explore count matches the reference-model LFSR sequence (mask 16'hB400) exactly.
